// File: rtl/duck_sprite_fetch_if.sv
// duck_sprite_fetch_if: raster coordinates, duck control pulses and sprite-ROM
// signals exchanged between the video pipeline (master) and the sprite fetch stage (slave).
interface duck_sprite_fetch_if #(parameter int ADDR_W = 13);
    logic [9:0]        DrawX;
    logic [9:0]        DrawY;
    logic              frame_start;
    logic [9:0]        DuckX;
    logic [9:0]        DuckY;
    logic              facing_left;
    logic              spawn;
    logic              shot;
    logic              fall_done;
    logic [ADDR_W-1:0] rom_addr;
    logic [3:0]        rom_data;
    logic [3:0]        palette_index;
    logic              pixel_hit;
    logic [1:0]        duck_state;

    modport master (
        output DrawX, DrawY, frame_start, DuckX, DuckY, facing_left,
        output spawn, shot, fall_done, rom_data,
        input  rom_addr, palette_index, pixel_hit, duck_state
    );

    modport slave (
        input  DrawX, DrawY, frame_start, DuckX, DuckY, facing_left,
        input  spawn, shot, fall_done, rom_data,
        output rom_addr, palette_index, pixel_hit, duck_state
    );
endinterface

// File: rtl/duck_sprite_fetch.sv
// duck_sprite_fetch: maps the raster position onto the duck sprite ROM with a fixed
// two-cycle latency, and runs the duck life-cycle FSM that picks the sprite frame.
module duck_sprite_fetch #(
    parameter int         SPRITE_W        = 32,
    parameter int         SPRITE_H        = 32,
    parameter int         FLY_FRAMES      = 4,
    parameter int         ANIM_DIV        = 6,
    parameter int         HIT_HOLD        = 30,
    parameter int         ADDR_W          = 13,
    parameter logic [3:0] TRANSPARENT_IDX = 4'h1
) (
    input logic                Clk,
    input logic                Reset_n,
    duck_sprite_fetch_if.slave bus
);
    localparam int CW = SPRITE_W > 1 ? $clog2(SPRITE_W) : 1;
    localparam int RW = SPRITE_H > 1 ? $clog2(SPRITE_H) : 1;
    localparam int FW = $clog2(FLY_FRAMES + 2);
    localparam int AW = FLY_FRAMES > 1 ? $clog2(FLY_FRAMES) : 1;
    localparam int DW = ANIM_DIV > 1 ? $clog2(ANIM_DIV) : 1;
    localparam int HW = HIT_HOLD > 1 ? $clog2(HIT_HOLD) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FLY  = 2'd1;
    localparam logic [1:0] HIT  = 2'd2;
    localparam logic [1:0] FALL = 2'd3;

    logic [1:0]    state;
    logic [AW-1:0] anim_frame;
    logic [DW-1:0] anim_div_cnt;
    logic [HW-1:0] hold_cnt;
    logic [9:0]    px, py;
    logic          mirror;
    logic [FW-1:0] frame_sel;

    logic [10:0]   x, y, x_lo, y_lo;
    logic          in_box;
    logic [CW-1:0] dcol, col;
    logic [RW-1:0] row;

    logic          box0, live0, box1, live1;
    logic [CW-1:0] col0;
    logic [RW-1:0] row0;
    logic [FW-1:0] frame0;

    always_comb frame_sel = state == FLY  ? FW'(anim_frame) :
                            state == HIT  ? FW'(FLY_FRAMES) :
                            state == FALL ? FW'(FLY_FRAMES + 1) : '0;

    // 11-bit compares keep px+SPRITE_W from wrapping near the right/bottom edge
    assign x      = {1'b0, bus.DrawX};
    assign y      = {1'b0, bus.DrawY};
    assign x_lo   = {1'b0, px};
    assign y_lo   = {1'b0, py};
    assign in_box = x >= x_lo && x < x_lo + 11'(SPRITE_W) &&
                    y >= y_lo && y < y_lo + 11'(SPRITE_H);
    assign dcol   = CW'(bus.DrawX - px);
    assign col    = mirror ? CW'(SPRITE_W - 1) - dcol : dcol;
    assign row    = RW'(bus.DrawY - py);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= IDLE;
            anim_frame   <= '0;
            anim_div_cnt <= '0;
            hold_cnt     <= '0;
            px           <= '0;
            py           <= '0;
            mirror       <= 1'b0;
        end else begin
            if (bus.frame_start) begin
                px     <= bus.DuckX;
                py     <= bus.DuckY;
                mirror <= bus.facing_left;
            end
            case (state)
                IDLE: if (bus.spawn) begin
                    state        <= FLY;
                    anim_frame   <= '0;
                    anim_div_cnt <= '0;
                end
                // a shot coinciding with frame_start wins and that pulse is not counted
                FLY: if (bus.shot) begin
                    state    <= HIT;
                    hold_cnt <= '0;
                end else if (bus.frame_start) begin
                    anim_div_cnt <= anim_div_cnt == DW'(ANIM_DIV - 1) ? '0 : anim_div_cnt + DW'(1);
                    if (anim_div_cnt == DW'(ANIM_DIV - 1))
                        anim_frame <= anim_frame == AW'(FLY_FRAMES - 1) ? '0 : anim_frame + AW'(1);
                end
                HIT: if (bus.frame_start) begin
                    if (hold_cnt == HW'(HIT_HOLD - 1))
                        state <= FALL;
                    else
                        hold_cnt <= hold_cnt + HW'(1);
                end
                FALL: if (bus.fall_done) state <= IDLE;
            endcase
        end
    end

    // frame and liveness ride with the coordinates so latency is state-independent
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            box0   <= 1'b0;
            live0  <= 1'b0;
            col0   <= '0;
            row0   <= '0;
            frame0 <= '0;
            box1   <= 1'b0;
            live1  <= 1'b0;
        end else begin
            box0   <= in_box;
            live0  <= state != IDLE;
            col0   <= col;
            row0   <= row;
            frame0 <= frame_sel;
            box1   <= box0;
            live1  <= live0;
        end
    end

    assign bus.rom_addr      = ADDR_W'(32'(frame0) * 32'(SPRITE_W * SPRITE_H) +
                                       32'(row0) * 32'(SPRITE_W) + 32'(col0));
    assign bus.palette_index = box1 ? bus.rom_data : 4'h0;
    assign bus.pixel_hit     = box1 & live1 & (bus.rom_data != TRANSPARENT_IDX);
    assign bus.duck_state    = state;
endmodule

// File: tb/tb_duck_sprite_fetch.sv
// tb_duck_sprite_fetch: randomized bench for duck_sprite_fetch against a frame-count
// based model of the duck life cycle and sprite geometry, with a synchronous ROM.
module tb_duck_sprite_fetch;
    localparam int W = 32, H = 32, NF = 4, AD = 6, HH = 30;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    duck_sprite_fetch_if #(.ADDR_W(13)) bus();
    duck_sprite_fetch dut (.Clk(clk), .Reset_n(rst_n), .bus(bus));

    logic [3:0] rom [0:8191];
    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    int checks = 0, errors = 0;

    int m_state, fly_fs, hit_fs, mx, my;
    bit mm;
    int prev_addr;
    bit prev_box, prev_live;
    int exp_addr;
    bit exp_box, exp_hit;
    logic [3:0] exp_pal;

    function automatic int base_frame();
        return m_state == 1 ? (fly_fs / AD) % NF : m_state == 2 ? NF : m_state == 3 ? NF + 1 : 0;
    endfunction

    task automatic model_reset();
        m_state = 0; fly_fs = 0; hit_fs = 0; mx = 0; my = 0; mm = 0;
        prev_addr = 0; prev_box = 0; prev_live = 0;
    endtask

    task automatic set_xy(input int x, input int y);
        bus.DrawX = 10'(x < 0 ? 0 : x > 1023 ? 1023 : x);
        bus.DrawY = 10'(y < 0 ? 0 : y > 1023 ? 1023 : y);
    endtask

    task automatic probe_near();
        set_xy(mx + int'($urandom_range(0, W + 7)) - 4, my + int'($urandom_range(0, H + 7)) - 4);
    endtask

    task automatic cyc(input bit fs, input bit sp, input bit sh, input bit fd);
        int dx, dy, c, a;
        bit b, l;
        bus.frame_start = fs; bus.spawn = sp; bus.shot = sh; bus.fall_done = fd;
        dx = int'(bus.DrawX) - mx;
        dy = int'(bus.DrawY) - my;
        b = dx >= 0 && dx < W && dy >= 0 && dy < H;
        c = mm ? W - 1 - dx : dx;
        a = base_frame() * W * H + dy * W + c;
        l = m_state != 0;
        @(posedge clk);
        if (fs) begin mx = int'(bus.DuckX); my = int'(bus.DuckY); mm = bus.facing_left; end
        case (m_state)
            0: if (sp) begin m_state = 1; fly_fs = 0; end
            1: if (sh) begin m_state = 2; hit_fs = 0; end else if (fs) fly_fs++;
            2: if (fs) begin hit_fs++; if (hit_fs == HH) m_state = 3; end
            default: if (fd) m_state = 0;
        endcase
        exp_pal = prev_box ? rom[prev_addr] : 4'h0;
        exp_hit = prev_box ? (prev_live && rom[prev_addr] != 4'h1) : 1'b0;
        exp_box = b; exp_addr = a;
        prev_box = b; prev_live = l; prev_addr = a;
        #1;
        bus.frame_start = 0; bus.spawn = 0; bus.shot = 0; bus.fall_done = 0;
    endtask

    task automatic test_reset();
        bus.DrawX = 0; bus.DrawY = 0; bus.DuckX = 0; bus.DuckY = 0; bus.facing_left = 0;
        bus.frame_start = 0; bus.spawn = 0; bus.shot = 0; bus.fall_done = 0;
        rst_n = 1'b0;
        model_reset();
        #12;
        checks++; if (bus.rom_addr !== 13'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", bus.rom_addr); end
        checks++; if (bus.palette_index !== 4'd0) begin errors++; $display("FAIL reset_pal got %0d want 0", bus.palette_index); end
        checks++; if (bus.pixel_hit !== 1'b0) begin errors++; $display("FAIL reset_hit got %0b want 0", bus.pixel_hit); end
        checks++; if (bus.duck_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", bus.duck_state); end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_origin();
        bus.DuckX = 100; bus.DuckY = 50; bus.facing_left = 0;
        cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 0);
        for (int x = 99; x <= 133; x++) begin
            set_xy(x, 50);
            cyc(0, 0, 0, 0);
            if (exp_box) begin
                checks++; if (bus.rom_addr !== 13'(exp_addr)) begin errors++; $display("FAIL origin_addr x=%0d got %0d want %0d", x, bus.rom_addr, exp_addr); end
            end
            checks++; if ({bus.palette_index, bus.pixel_hit} !== {exp_pal, exp_hit}) begin
                errors++; $display("FAIL origin_pix x=%0d got %0d/%0b want %0d/%0b", x - 1, bus.palette_index, bus.pixel_hit, exp_pal, exp_hit);
            end
            if (x == 103) begin
                checks++; if (bus.rom_addr !== 13'd3) begin errors++; $display("FAIL origin_x103 got %0d want 3", bus.rom_addr); end
            end
        end
        checks++; if (bus.duck_state !== 2'(m_state)) begin errors++; $display("FAIL origin_state got %0d want %0d", bus.duck_state, m_state); end
    endtask

    task automatic test_mirror();
        bus.facing_left = 1;
        cyc(1, 0, 0, 0);
        set_xy(100, 51);
        cyc(0, 0, 0, 0);
        checks++; if (bus.rom_addr !== 13'd63) begin errors++; $display("FAIL mirror_r1 got %0d want 63", bus.rom_addr); end
        for (int i = 0; i < 20; i++) begin
            probe_near();
            cyc(0, 0, 0, 0);
            if (exp_box) begin
                checks++; if (bus.rom_addr !== 13'(exp_addr)) begin errors++; $display("FAIL mirror_addr got %0d want %0d", bus.rom_addr, exp_addr); end
            end
            checks++; if ({bus.palette_index, bus.pixel_hit} !== {exp_pal, exp_hit}) begin
                errors++; $display("FAIL mirror_pix got %0d/%0b want %0d/%0b", bus.palette_index, bus.pixel_hit, exp_pal, exp_hit);
            end
        end
    endtask

    task automatic test_anim();
        for (int f = 0; f < 24; f++) begin
            bus.DuckX = 10'($urandom_range(0, 639));
            bus.DuckY = 10'($urandom_range(0, 479));
            bus.facing_left = 1'($urandom_range(0, 1));
            cyc(1, 0, 0, 0);
            for (int i = 0; i < 6; i++) begin
                probe_near();
                cyc(0, 0, 0, 0);
                if (exp_box) begin
                    checks++; if (bus.rom_addr !== 13'(exp_addr)) begin errors++; $display("FAIL anim_addr fs=%0d got %0d want %0d", fly_fs, bus.rom_addr, exp_addr); end
                end
                checks++; if ({bus.palette_index, bus.pixel_hit} !== {exp_pal, exp_hit}) begin
                    errors++; $display("FAIL anim_pix got %0d/%0b want %0d/%0b", bus.palette_index, bus.pixel_hit, exp_pal, exp_hit);
                end
            end
        end
    endtask

    task automatic test_hit_fall();
        bus.DuckX = 200; bus.DuckY = 100; bus.facing_left = 0;
        cyc(1, 0, 1, 0);
        checks++; if (bus.duck_state !== 2'd2) begin errors++; $display("FAIL hit_enter got %0d want 2", bus.duck_state); end
        for (int f = 0; f < HH; f++) begin
            cyc(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            for (int i = 0; i < 3; i++) begin
                probe_near();
                cyc(0, 0, 0, 0);
                if (exp_box) begin
                    checks++; if (bus.rom_addr !== 13'(exp_addr)) begin errors++; $display("FAIL hit_addr st=%0d got %0d want %0d", m_state, bus.rom_addr, exp_addr); end
                end
                checks++; if ({bus.palette_index, bus.pixel_hit} !== {exp_pal, exp_hit}) begin
                    errors++; $display("FAIL hit_pix got %0d/%0b want %0d/%0b", bus.palette_index, bus.pixel_hit, exp_pal, exp_hit);
                end
            end
            checks++; if (bus.duck_state !== 2'(m_state)) begin errors++; $display("FAIL hit_state f=%0d got %0d want %0d", f, bus.duck_state, m_state); end
        end
        checks++; if (bus.duck_state !== 2'd3) begin errors++; $display("FAIL fall_enter got %0d want 3", bus.duck_state); end
        cyc(0, 0, 1, 1);
        checks++; if (bus.duck_state !== 2'd0) begin errors++; $display("FAIL fall_exit got %0d want 0", bus.duck_state); end
        for (int i = 0; i < 8; i++) begin
            set_xy(mx + int'($urandom_range(0, W - 1)), my + int'($urandom_range(0, H - 1)));
            cyc(0, 0, 0, 0);
            if (i >= 2) begin
                checks++; if (bus.pixel_hit !== 1'b0) begin errors++; $display("FAIL idle_hit got %0b want 0", bus.pixel_hit); end
            end
            checks++; if (bus.palette_index !== exp_pal) begin errors++; $display("FAIL idle_pal got %0d want %0d", bus.palette_index, exp_pal); end
        end
    endtask

    task automatic test_reset_mid();
        cyc(0, 1, 0, 0);
        cyc(0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            set_xy(mx + int'($urandom_range(0, W - 1)), my + int'($urandom_range(0, H - 1)));
            cyc(0, 0, 0, 0);
        end
        checks++; if (bus.duck_state !== 2'd2) begin errors++; $display("FAIL mid_pre got %0d want 2", bus.duck_state); end
        @(negedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if ({bus.rom_addr, bus.palette_index, bus.pixel_hit, bus.duck_state} !== 20'd0) begin
            errors++; $display("FAIL mid_reset got addr=%0d pal=%0d hit=%0b st=%0d want all 0", bus.rom_addr, bus.palette_index, bus.pixel_hit, bus.duck_state);
        end
        @(negedge clk) rst_n = 1'b1;
        cyc(0, 0, 1, 0);
        checks++; if (bus.duck_state !== 2'd0) begin errors++; $display("FAIL mid_shot got %0d want 0", bus.duck_state); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                bus.DuckX = 10'($urandom_range(0, 639));
                bus.DuckY = 10'($urandom_range(0, 479));
                bus.facing_left = 1'($urandom_range(0, 1));
            end
            probe_near();
            cyc($urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0);
            if (exp_box) begin
                checks++; if (bus.rom_addr !== 13'(exp_addr)) begin errors++; $display("FAIL rand_addr i=%0d got %0d want %0d", i, bus.rom_addr, exp_addr); end
            end
            checks++; if ({bus.palette_index, bus.pixel_hit} !== {exp_pal, exp_hit}) begin
                errors++; $display("FAIL rand_pix i=%0d got %0d/%0b want %0d/%0b", i, bus.palette_index, bus.pixel_hit, exp_pal, exp_hit);
            end
            checks++; if (bus.duck_state !== 2'(m_state)) begin errors++; $display("FAIL rand_state i=%0d got %0d want %0d", i, bus.duck_state, m_state); end
        end
    endtask

    initial begin
        for (int i = 0; i < 8192; i++)
            rom[i] = ($urandom_range(0, 3) == 0) ? 4'h1 : 4'($urandom_range(0, 15));
        test_reset();
        test_origin();
        test_mirror();
        test_anim();
        test_hit_fall();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
